// File: rtl/rv32_wb_arbiter.sv
// Register-file write-port arbiter: pipeline results take priority over a buffered long-latency-unit FIFO,
// with a busy scoreboard for decode hazards. Optional LU bypass: define RV32_WB_LU_BYPASS_EN.
module rv32_wb_arbiter #(
  parameter int unsigned LU_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid_in,
  input  logic [4:0]  pipe_rd_in,
  input  logic [31:0] pipe_value_in,
  input  logic        pipe_flush_in,
  input  logic        lu_valid_in,
  output logic        lu_ready_out,
  input  logic [4:0]  lu_rd_in,
  input  logic [31:0] lu_value_in,
  input  logic        issue_valid_in,
  input  logic [4:0]  issue_rd_in,
  input  logic [4:0]  rs1_in,
  input  logic [4:0]  rs2_in,
  input  logic [4:0]  rd_chk_in,
  output logic        hazard_out,
  output logic [4:0]  rd_out,
  output logic [31:0] rd_value_out,
  output logic        rd_write_out
);

  localparam int unsigned PTR_W = $clog2(LU_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [4:0]       r_fifo_rd  [LU_DEPTH];
  logic [31:0]      r_fifo_val [LU_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_busy;

  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_pipe_sel;
  logic        w_sel;
  logic        w_pop;
  logic        w_push;
  logic        w_bypass;
  logic        w_clr;
  logic [4:0]  w_sel_rd;
  logic [31:0] w_sel_val;
  logic [31:0] w_busy_nxt;

  assign w_full       = (r_count == CNT_W'(LU_DEPTH));
  assign w_empty      = (r_count == '0);
  assign lu_ready_out = !reset && !w_full;
  assign w_accept     = lu_valid_in && lu_ready_out;
  assign w_pipe_sel   = pipe_valid_in && !pipe_flush_in;

  always_comb begin
    w_sel     = 1'b0;
    w_pop     = 1'b0;
    w_bypass  = 1'b0;
    w_sel_rd  = '0;
    w_sel_val = '0;
    if (w_pipe_sel) begin
      w_sel     = 1'b1;
      w_sel_rd  = pipe_rd_in;
      w_sel_val = pipe_value_in;
    end else if (!w_empty) begin
      w_sel     = 1'b1;
      w_pop     = 1'b1;
      w_sel_rd  = r_fifo_rd[r_rd_ptr];
      w_sel_val = r_fifo_val[r_rd_ptr];
    end
`ifdef RV32_WB_LU_BYPASS_EN
    else if (w_accept) begin
      w_sel     = 1'b1;
      w_bypass  = 1'b1;
      w_sel_rd  = lu_rd_in;
      w_sel_val = lu_value_in;
    end
`endif
  end

  // A bypassed result is consumed directly, so it never occupies a FIFO slot.
  assign w_push = w_accept && !w_bypass;
  assign w_clr  = w_pop || w_bypass;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]  <= lu_rd_in;
      r_fifo_val[r_wr_ptr] <= lu_value_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear before set so that a same-cycle issue to the retiring register keeps it busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_clr) w_busy_nxt[w_sel_rd] = 1'b0;
    if (issue_valid_in && (issue_rd_in != '0)) w_busy_nxt[issue_rd_in] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  assign hazard_out = r_busy[rs1_in] | r_busy[rs2_in] | r_busy[rd_chk_in];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_out       <= '0;
      rd_value_out <= '0;
      rd_write_out <= 1'b0;
    end else if (w_sel) begin
      rd_out       <= w_sel_rd;
      rd_value_out <= w_sel_val;
      rd_write_out <= (w_sel_rd != '0);
    end else begin
      rd_write_out <= 1'b0;
    end
  end

  a_issue_not_busy: assert property (@(posedge clk) disable iff (reset)
    (issue_valid_in && (issue_rd_in != '0)) |->
      (!r_busy[issue_rd_in] || (w_clr && (w_sel_rd == issue_rd_in))));

endmodule
